udp_frame_sched: RTL
====================

# udp_frame_sched

Ping-pong capture scheduler between the NCO sample stream and the UDP transmit path. It writes incoming 32-bit samples into the 512-word dual-port packet RAM, treating it as two 256-word halves. When a half is complete it raises `tx_trig` to the UDP block with that half's base address, then waits for `tx_done` before releasing the half for refill. It replaces the free-running counter-based trigger and address generation with a handshaked, overflow-counting scheduler.

## Interface
- `ADDR_W`, 9: RAM word-address width; half depth is 2^(ADDR_W-1) = 256.
- `DATA_W`, 32: sample/RAM word width, packed as {fcos, fsin}.
- `TRIG_WIDTH`, 8: length of the `tx_trig` pulse in cycles, minimum 1.
- `fpga_gclk`  in  1  single clock; all ports are synchronous to it.
- `reset`  in  1  synchronous, active-high reset.
- `enable`  in  1  capture enable; samples are ignored while low.
- `sample_valid`  in  1  `sample_data` is valid this cycle.
- `sample_data`  in  DATA_W  sample word.
- `ram_wren`  out  1  RAM write strobe, registered.
- `ram_wraddr`  out  ADDR_W  RAM write address, registered.
- `ram_wdata`  out  DATA_W  RAM write data, registered.
- `tx_trig`  out  1  transmit request, high for TRIG_WIDTH cycles.
- `tx_base`  out  ADDR_W  base address of the half to send: 0 or 256. Stable from `tx_trig` rise until `tx_done` is accepted.
- `tx_done`  in  1  single-cycle pulse from the transmit side. It is already synchronized to `fpga_gclk` upstream.
- `half_full`  out  2  full flag per half.
- `overflow_cnt`  out  16  dropped-sample count; saturates at 0xFFFF.
- `frame_cnt`  out  16  completed transmissions; wraps.
- `tx_state`  out  2  TX FSM state, for debug.

## Operation
- Write side registers:
  - `wr_half` (1 bit) selects the half being filled.
  - `wr_idx` (ADDR_W-1 bits) is the word index within that half.
- Accept condition: `enable & sample_valid & ~half_full[wr_half]`.
  - Next cycle: `ram_wren`=1, `ram_wraddr`={wr_half, wr_idx}, `ram_wdata`=sample_data.
- Accept with `wr_idx`=255:
  - set `half_full[wr_half]`;
  - toggle `wr_half`;
  - set `wr_idx` to 0.
  - Otherwise `wr_idx` increments by 1.
- Drop condition: `enable & sample_valid & half_full[wr_half]`.
  - No write occurs.
  - `overflow_cnt` increments, saturating at 0xFFFF.
- `enable` low mid-half: a partially filled half keeps `wr_idx`. Capture resumes at the same address when `enable` returns high.
- TX FSM, with a `tx_half` pointer that starts at 0:
  - IDLE(0): if `half_full[tx_half]`, latch `tx_base`={tx_half, 0…0}, load the trigger counter, go to TRIG.
  - TRIG(1): `tx_trig`=1; the counter decrements each cycle. After TRIG_WIDTH cycles, go to WAIT.
  - WAIT(2): on `tx_done`, do all of the following, then go to IDLE:
    - clear `half_full[tx_half]`;
    - toggle `tx_half`;
    - increment `frame_cnt`.
  - `tx_done` in IDLE or TRIG is ignored.
- Halves are sent strictly alternately, in fill order.
- Simultaneous set and clear on different halves in the same cycle: both take effect. Set and clear on the same half cannot occur in the same cycle: a set requires the flag clear, and a clear requires it set.
- Reset values: all outputs 0, `wr_half`=0, `wr_idx`=0, `tx_half`=0, FSM in IDLE.
- Reset mid-operation: `tx_trig` drops at the reset edge. All buffered data is abandoned and both halves read as empty.

## Timing
- Sample accepted at edge N: the RAM write strobe is high during cycle N→N+1. Write latency is one cycle.
- Last word of a half accepted at edge N: `half_full` rises at N, and TRIG is entered at edge N+1. `tx_trig` is high for cycles N+1 … N+TRIG_WIDTH.
- `tx_done` at edge M in WAIT:
  - `half_full` clears at M and FSM returns to IDLE at M.
  - If the other half is already full, TRIG is entered at M+1.
- With no stalls, one sample per cycle is sustained. Minimum tx turnaround is TRIG_WIDTH+2 cycles per half.

## Test plan
- Reset, `enable`=1, 256 consecutive valid samples 0…255 → RAM writes at addresses 0…255 with data equal to the sample value; `tx_trig` high for 8 cycles starting 1 cycle after the last accept; `tx_base`=0; `half_full`=01.
- Continue 256 more samples with no `tx_done` → writes at 256…511; `half_full`=11; no second `tx_trig`. Then 10 extra samples → `overflow_cnt`=10 and no writes.
- Then pulse `tx_done` → `frame_cnt`=1 and `half_full`=10; `tx_trig` rises again the next cycle with `tx_base`=256. A second `tx_done` → `frame_cnt`=2 and `half_full`=00.
- Toggle `enable` low after 100 samples for 50 cycles while `sample_valid` stays high → no writes and no overflow increments; capture resumes at address 100.
- Pulse `tx_done` during IDLE and during TRIG → ignored: `frame_cnt` and `half_full` unchanged.
- Assert `reset` in the 3rd TRIG cycle → the next cycle shows `tx_trig`=0, all counters 0, `half_full`=00; the next sample is written to address 0.

Source files
------------

// File: rtl/udp_frame_sched.sv
// ---------------------------------------------------------------------------
// udp_frame_sched
//   Ping-pong capture scheduler between the NCO sample stream and the UDP
//   transmit path. Samples are written into a dual-port packet RAM that is
//   split into two halves. A completed half is handed to the UDP block with a
//   tx_trig pulse and its base address, and it is refilled only after the
//   UDP block returns tx_done. Samples that arrive while the half being
//   filled is still owned by the transmitter are dropped and counted.
//
// Ports
//   fpga_gclk     in   single clock
//   reset         in   synchronous active-high reset
//   enable        in   capture enable; samples ignored while low
//   sample_valid  in   sample_data valid this cycle
//   sample_data   in   DATA_W sample word {fcos, fsin}
//   ram_wren      out  registered RAM write strobe
//   ram_wraddr    out  registered RAM write address
//   ram_wdata     out  registered RAM write data
//   tx_trig       out  transmit request, high for TRIG_WIDTH cycles
//   tx_base       out  base address of the half to send (0 or half depth)
//   tx_done       in   single-cycle transmit-complete pulse
//   half_full     out  full flag per half
//   overflow_cnt  out  dropped-sample count, saturating
//   frame_cnt     out  completed transmissions, wrapping
//   tx_state      out  TX FSM state for debug
// ---------------------------------------------------------------------------
module udp_frame_sched #(
    parameter int ADDR_W     = 9,
    parameter int DATA_W     = 32,
    parameter int TRIG_WIDTH = 8
) (
    input  logic              fpga_gclk,
    input  logic              reset,
    input  logic              enable,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample_data,
    output logic              ram_wren,
    output logic [ADDR_W-1:0] ram_wraddr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              tx_trig,
    output logic [ADDR_W-1:0] tx_base,
    input  logic              tx_done,
    output logic [1:0]        half_full,
    output logic [15:0]       overflow_cnt,
    output logic [15:0]       frame_cnt,
    output logic [1:0]        tx_state
);

    localparam int IDX_W = ADDR_W - 1;
    localparam int CNT_W = (TRIG_WIDTH > 1) ? $clog2(TRIG_WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_TRIG = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   trig_cnt_q, trig_cnt_d;
    logic               tx_half_q, tx_half_d;
    logic [ADDR_W-1:0]  tx_base_q, tx_base_d;
    logic               wr_half_q, wr_half_d;
    logic [IDX_W-1:0]   wr_idx_q, wr_idx_d;
    logic [1:0]         half_full_q, half_full_d;
    logic [15:0]        ovf_q, ovf_d;
    logic [15:0]        frame_q, frame_d;
    logic               wren_q, wren_d;
    logic [ADDR_W-1:0]  wraddr_q, wraddr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;

    logic               accept, drop;
    logic [1:0]         set_mask, clr_mask;

    always_comb begin
        state_d    = state_q;
        trig_cnt_d = trig_cnt_q;
        tx_half_d  = tx_half_q;
        tx_base_d  = tx_base_q;
        wr_half_d  = wr_half_q;
        wr_idx_d   = wr_idx_q;
        ovf_d      = ovf_q;
        frame_d    = frame_q;
        wren_d     = 1'b0;
        wraddr_d   = wraddr_q;
        wdata_d    = wdata_q;
        set_mask   = 2'b00;
        clr_mask   = 2'b00;

        accept = enable & sample_valid & ~half_full_q[wr_half_q];
        drop   = enable & sample_valid &  half_full_q[wr_half_q];

        // Write side: fill the current half, hand it over on its last word.
        if (accept) begin
            wren_d   = 1'b1;
            wraddr_d = {wr_half_q, wr_idx_q};
            wdata_d  = sample_data;
            if (wr_idx_q == '1) begin
                set_mask[wr_half_q] = 1'b1;
                wr_half_d           = ~wr_half_q;
                wr_idx_d            = '0;
            end else begin
                wr_idx_d = wr_idx_q + IDX_W'(1);
            end
        end

        if (drop && (ovf_q != 16'hFFFF)) begin
            ovf_d = ovf_q + 16'd1;
        end

        // TX side: halves are released strictly in fill order via tx_half.
        case (state_q)
            S_IDLE: begin
                if (half_full_q[tx_half_q]) begin
                    tx_base_d  = {tx_half_q, {IDX_W{1'b0}}};
                    trig_cnt_d = CNT_W'(TRIG_WIDTH - 1);
                    state_d    = S_TRIG;
                end
            end
            S_TRIG: begin
                if (trig_cnt_q == '0) begin
                    state_d = S_WAIT;
                end else begin
                    trig_cnt_d = trig_cnt_q - CNT_W'(1);
                end
            end
            S_WAIT: begin
                if (tx_done) begin
                    clr_mask[tx_half_q] = 1'b1;
                    tx_half_d           = ~tx_half_q;
                    frame_d             = frame_q + 16'd1;
                    state_d             = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Set and clear never target the same half in one cycle.
        half_full_d = (half_full_q | set_mask) & ~clr_mask;
    end

    always_ff @(posedge fpga_gclk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            trig_cnt_q  <= '0;
            tx_half_q   <= 1'b0;
            tx_base_q   <= '0;
            wr_half_q   <= 1'b0;
            wr_idx_q    <= '0;
            half_full_q <= 2'b00;
            ovf_q       <= '0;
            frame_q     <= '0;
            wren_q      <= 1'b0;
            wraddr_q    <= '0;
            wdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            trig_cnt_q  <= trig_cnt_d;
            tx_half_q   <= tx_half_d;
            tx_base_q   <= tx_base_d;
            wr_half_q   <= wr_half_d;
            wr_idx_q    <= wr_idx_d;
            half_full_q <= half_full_d;
            ovf_q       <= ovf_d;
            frame_q     <= frame_d;
            wren_q      <= wren_d;
            wraddr_q    <= wraddr_d;
            wdata_q     <= wdata_d;
        end
    end

    assign ram_wren     = wren_q;
    assign ram_wraddr   = wraddr_q;
    assign ram_wdata    = wdata_q;
    assign tx_trig      = (state_q == S_TRIG);
    assign tx_base      = tx_base_q;
    assign half_full    = half_full_q;
    assign overflow_cnt = ovf_q;
    assign frame_cnt    = frame_q;
    assign tx_state     = state_q;

endmodule
